// File: rtl/mips_bus_ram.sv
// mips_bus_ram: word-organised RAM behind a stalling request/waitrequest bus.
// Each transfer passes through IDLE (latch request), WAIT_CYCLES stall cycles
// in WAIT, and a single ACCESS cycle in which waitrequest is low.
//
// Handshake: the master raises read or write and holds address, writedata,
// byteenable and the operation steady while waitrequest is high. The transfer
// completes on the rising edge that closes the cycle in which waitrequest is
// low. Read data is valid only in that cycle. Dropping or changing the request
// before completion aborts the transfer and sets the sticky proto_err flag.
module mips_bus_ram #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        proto_err,
  output logic [1:0]  state_dbg
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;

  // Request captured in IDLE; later cycles compare the live bus against it.
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        op_wr_q;
  logic        ok_q;
  logic [AW-1:0] idx_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Live decode of the bus request.
  logic          req;
  logic          live_op_wr;
  logic [31:0]   live_off;
  logic [31:0]   live_widx;
  logic          live_aligned;
  logic          live_ok;
  logic [AW-1:0] live_idx;
  logic          hold_ok;

  // Next-state control outputs.
  logic          err_set;
  logic          mem_we;
  logic          rd_load;
  logic          rd_ok;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_val;

  assign req          = read | write;
  assign live_op_wr   = write & ~read;  // read+write together is served as a read
  assign live_off     = address - BASE_ADDR;
  assign live_widx    = live_off >> 2;
  assign live_aligned = (address[1:0] == 2'b00);
  assign live_ok      = live_aligned && (live_widx < 32'(DEPTH_WORDS));
  assign live_idx     = live_widx[AW-1:0];

  assign hold_ok = req && (address == addr_q) && (live_op_wr == op_wr_q) &&
                   (writedata == wdata_q) && (byteenable == be_q);

  assign waitrequest = req && (state != S_ACCESS);
  assign state_dbg   = state;

  // Memory image: all zero at time zero; never touched by reset.
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  // Next-state, stall counter, error detection and memory strobes.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_set  = 1'b0;
    mem_we   = 1'b0;
    rd_load  = 1'b0;
    rd_ok    = ok_q;
    rd_idx   = idx_q;
    case (state)
      S_IDLE: begin
        rd_ok  = live_ok;
        rd_idx = live_idx;
        if (req) begin
          if ((read && write) || !live_aligned) err_set = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = S_ACCESS;
            rd_load  = ~live_op_wr;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (!hold_ok) begin
          err_set  = 1'b1;
          state_nx = S_IDLE;
          cnt_nx   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_nx = S_ACCESS;
          cnt_nx   = 4'd0;
          rd_load  = ~op_wr_q;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_ACCESS: begin
        state_nx = S_IDLE;
        if (!hold_ok) err_set = 1'b1;
        else          mem_we  = op_wr_q & ok_q;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
    rd_val = rd_ok ? mem[rd_idx] : 32'h0;
  end

  // State, counter, sticky error and read-data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      readdata  <= 32'h0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (err_set) proto_err <= 1'b1;
      if (rd_load) readdata  <= rd_val;
    end
  end

  // Request capture while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      op_wr_q <= 1'b0;
      ok_q    <= 1'b0;
      idx_q   <= '0;
    end else if (state == S_IDLE) begin
      addr_q  <= address;
      wdata_q <= writedata;
      be_q    <= byteenable;
      op_wr_q <= live_op_wr;
      ok_q    <= live_ok;
      idx_q   <= live_idx;
    end
  end

  // Byte-lane write at the edge closing a clean ACCESS cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_ram.sv
// Directed bench for mips_bus_ram: one instance with two stall cycles, one
// with none, sharing clock and reset.
module tb_mips_bus_ram;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (WAIT_CYCLES=2) ----------------
  logic [31:0] address_a = '0, writedata_a = '0, readdata_a;
  logic        read_a = 1'b0, write_a = 1'b0, waitrequest_a, proto_err_a;
  logic [3:0]  byteenable_a = '0;
  logic [1:0]  state_a;

  mips_bus_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut_a (
    .clk(clk), .reset(reset), .address(address_a), .read(read_a), .write(write_a),
    .writedata(writedata_a), .byteenable(byteenable_a), .waitrequest(waitrequest_a),
    .readdata(readdata_a), .proto_err(proto_err_a), .state_dbg(state_a)
  );

  // ---------------- DUT B (WAIT_CYCLES=0) ----------------
  logic [31:0] address_b = '0, writedata_b = '0, readdata_b;
  logic        read_b = 1'b0, write_b = 1'b0, waitrequest_b, proto_err_b;
  logic [3:0]  byteenable_b = '0;
  logic [1:0]  state_b;

  mips_bus_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut_b (
    .clk(clk), .reset(reset), .address(address_b), .read(read_b), .write(write_b),
    .writedata(writedata_b), .byteenable(byteenable_b), .waitrequest(waitrequest_b),
    .readdata(readdata_b), .proto_err(proto_err_b), .state_dbg(state_b)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit b, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    if (b) begin
      read_b = rd; write_b = wr; address_b = addr; writedata_b = wd; byteenable_b = be;
    end else begin
      read_a = rd; write_a = wr; address_a = addr; writedata_a = wd; byteenable_a = be;
    end
  endtask

  // One full transfer; returns the number of cycles the request was held and
  // the read data seen in the cycle waitrequest dropped.
  task automatic xfer(input bit b, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output int cyc, output logic [31:0] rdata);
    @(posedge clk); #1;
    drive(b, rd, wr, addr, wd, be);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((b ? waitrequest_b : waitrequest_a) && cyc < 32);
    rdata = b ? readdata_b : readdata_a;
    @(posedge clk); #1;
    drive(b, 1'b0, 1'b0, addr, wd, be);
  endtask

  task automatic write_word(input string tag, input bit b, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be, input int exp_cyc);
    int cyc;
    logic [31:0] rdata;
    xfer(b, 1'b0, 1'b1, addr, wd, be, cyc, rdata);
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic read_check(input string tag, input bit b, input logic [31:0] addr,
                            input logic [31:0] exp, input int exp_cyc);
    int cyc;
    logic [31:0] rdata;
    exp_q.push_back(exp);
    xfer(b, 1'b1, 1'b0, addr, 32'h0, 4'h0, cyc, rdata);
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_data"}, rdata, exp_q.pop_front());
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [31:0] rdata;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_a), 32'd0);
    check("rst_readdata", readdata_a, 32'h0);
    check("rst_proto_err", 32'(proto_err_a), 32'd0);
    check("rst_waitreq", 32'(waitrequest_a), 32'd0);
    reset = 1'b1;

    // Full-word write then read-back, four cycles each.
    write_word("wr_full", 1'b0, BASE + 32'd4, 32'hDEADBEEF, 4'hF, 4);
    read_check("rd_full", 1'b0, BASE + 32'd4, 32'hDEADBEEF, 4);

    // Single byte lane 1.
    write_word("wr_lane1", 1'b0, BASE + 32'd4, 32'h00001200, 4'b0010, 4);
    read_check("rd_lane1", 1'b0, BASE + 32'd4, 32'hDEAD12EF, 4);

    // No lanes enabled: completes, nothing changes.
    write_word("wr_be0", 1'b0, BASE + 32'd4, 32'h12345678, 4'b0000, 4);
    read_check("rd_be0", 1'b0, BASE + 32'd4, 32'hDEAD12EF, 4);
    check("be0_proto_err", 32'(proto_err_a), 32'd0);

    // Unwritten word reads as zero.
    read_check("rd_zero", 1'b0, BASE + 32'd12, 32'h0, 4);

    // Last word and beyond the end (index 16 must not alias word 0).
    write_word("wr_last", 1'b0, BASE + 32'd60, 32'h600DF00D, 4'hF, 4);
    read_check("rd_last", 1'b0, BASE + 32'd60, 32'h600DF00D, 4);
    write_word("wr_oob", 1'b0, BASE + 32'd64, 32'h55555555, 4'hF, 4);
    read_check("rd_word0", 1'b0, BASE, 32'h0, 4);
    read_check("rd_oob", 1'b0, BASE + 32'd64, 32'h0, 4);
    read_check("rd_below", 1'b0, BASE - 32'd4, 32'h0, 4);
    check("oob_proto_err", 32'(proto_err_a), 32'd0);

    // read and write together: served as a read, flagged.
    xfer(1'b0, 1'b1, 1'b1, BASE + 32'd4, 32'h0BADF00D, 4'hF, cyc, rdata);
    check("rw_cycles", 32'(cyc), 32'd4);
    check("rw_data", rdata, 32'hDEAD12EF);
    check("rw_proto_err", 32'(proto_err_a), 32'd1);
    read_check("rw_rdback", 1'b0, BASE + 32'd4, 32'hDEAD12EF, 4);
    pulse_reset();

    // Misaligned read: zero data, flag rises, reset clears it.
    read_check("rd_misalign", 1'b0, BASE + 32'd2, 32'h0, 4);
    check("misalign_proto_err", 32'(proto_err_a), 32'd1);
    pulse_reset();
    check("misalign_cleared", 32'(proto_err_a), 32'd0);

    // Write dropped during WAIT: abort, no memory change.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, BASE + 32'd4, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    check("drop_in_wait", 32'(state_a), 32'd1);
    write_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop_proto_err", 32'(proto_err_a), 32'd1);
    check("drop_state", 32'(state_a), 32'd0);
    read_check("drop_rdback", 1'b0, BASE + 32'd4, 32'hDEAD12EF, 4);
    pulse_reset();

    // Reset during WAIT of a write.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, BASE + 32'd4, 32'h11111111, 4'hF);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rstmid_waitreq", 32'(waitrequest_a), 32'd1);
    check("rstmid_state", 32'(state_a), 32'd0);
    write_a = 1'b0;
    #1;
    check("rstmid_waitreq_idle", 32'(waitrequest_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    read_check("rstmid_rdback", 1'b0, BASE + 32'd4, 32'hDEAD12EF, 4);

    // Zero-stall instance.
    write_word("b_wr", 1'b1, BASE, 32'hA5A5A5A5, 4'hF, 2);
    read_check("b_rd", 1'b1, BASE, 32'hA5A5A5A5, 2);
    read_check("b_oob", 1'b1, BASE + 32'(4 * DEPTH), 32'h0, 2);
    check("b_oob_proto_err", 32'(proto_err_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
